// File: rtl/rv_pkg.sv
// Shared RISC-V front-end types and helpers.
// Halfword buffer entry, XLEN derivation, length decode.
package rv_pkg;

  localparam int HW_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [15:0] data;
    logic        fault;
  } rv_halfword_t;

  function automatic int rv_xlen(input bit rv64);
    return rv64 ? 64 : 32;
  endfunction

  function automatic logic halfword_is_compressed(
    input logic [15:0] hw
  );
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rv_halfword_fifo.sv
// Four-entry halfword shift FIFO, head at index 0.
// Pops 0-2, pushes 0-2 per cycle; flush wins over both.
module rv_halfword_fifo
  import rv_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic [1:0]   push_n,
  input  rv_halfword_t push0,
  input  rv_halfword_t push1,
  input  logic [1:0]   pop_n,
  output logic [2:0]   count,
  output rv_halfword_t entry0,
  output rv_halfword_t entry1
);

  localparam rv_halfword_t HW_ZERO = '0;

  rv_halfword_t q     [HW_FIFO_DEPTH];
  rv_halfword_t q_nxt [HW_FIFO_DEPTH];
  logic [2:0]   base;
  logic [2:0]   count_nxt;

  // Shift out popped entries, then append pushed ones after survivors.
  always_comb begin
    base      = count - {1'b0, pop_n};
    count_nxt = base + {1'b0, push_n};
    unique case (pop_n)
      2'd1:    q_nxt = '{q[1], q[2], q[3], HW_ZERO};
      2'd2:    q_nxt = '{q[2], q[3], HW_ZERO, HW_ZERO};
      default: q_nxt = q;
    endcase
    for (int i = 0; i < HW_FIFO_DEPTH; i++) begin
      if (push_n != 2'd0 && 3'(i) == base)
        q_nxt[i] = push0;
      if (push_n == 2'd2 && 3'(i) == base + 3'd1)
        q_nxt[i] = push1;
    end
  end

  // Storage and occupancy.
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      count <= '0;
      for (int i = 0; i < HW_FIFO_DEPTH; i++)
        q[i] <= HW_ZERO;
    end else begin
      count <= count_nxt;
      q     <= q_nxt;
    end
  end

  assign entry0 = q[0];
  assign entry1 = q[1];

endmodule

// File: rtl/rv_fetch_aligner.sv
// Repacks aligned 32-bit fetch words into 16/32-bit
// instructions at halfword PCs, with fault propagation.
module rv_fetch_aligner
  import rv_pkg::*;
#(
  parameter bit          rv64     = 1'b1,
  parameter logic [63:0] RESET_PC = 64'h0,
  localparam int         XLEN     = rv_xlen(rv64)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic            in_fault,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault
);

  logic [XLEN-1:0] pc;
  logic            skip_low;
  logic            halted;
  logic [2:0]      count;
  rv_halfword_t    head;
  rv_halfword_t    second;
  rv_halfword_t    push0;
  rv_halfword_t    push1;
  logic [1:0]      push_n;
  logic [1:0]      pop_n;
  logic            compressed;
  logic            push;
  logic            pop;
  logic            flush;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc[0];

  assign compressed = halfword_is_compressed(head.data);
  assign in_ready   = !redirect && !halted && count <= 3'd2;
  assign push       = in_valid && in_ready;
  assign out_valid  = !halted && count != 3'd0 &&
                      (head.fault || compressed || count >= 3'd2);
  assign out_fault  = head.fault ||
                      (!compressed && count >= 3'd2 && second.fault);
  assign out_instr  = {count >= 3'd2 ? second.data : 16'h0,
                       head.data};
  assign out_pc     = pc;
  assign pop        = out_valid && out_ready;
  assign flush      = redirect || (pop && out_fault);

  assign push0 = '{data: skip_low ? in_data[31:16] : in_data[15:0],
                   fault: in_fault};
  assign push1 = '{data: in_data[31:16], fault: in_fault};

  // Halfword counts moved into and out of the buffer this cycle.
  always_comb begin
    push_n = 2'd0;
    pop_n  = 2'd0;
    if (push)
      push_n = skip_low ? 2'd1 : 2'd2;
    unique case (1'b1)
      (pop && !out_fault && compressed):  pop_n = 2'd1;
      (pop && !out_fault && !compressed): pop_n = 2'd2;
      default:                            pop_n = 2'd0;
    endcase
  end

  rv_halfword_fifo u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .push_n  (push_n),
    .push0   (push0),
    .push1   (push1),
    .pop_n   (pop_n),
    .count   (count),
    .entry0  (head),
    .entry1  (second)
  );

  // PC, first-word skip and fault-halt tracking.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc       <= RESET_PC[XLEN-1:0];
      skip_low <= RESET_PC[1];
      halted   <= 1'b0;
    end else if (redirect) begin
      pc       <= {redirect_pc[XLEN-1:1], 1'b0};
      skip_low <= redirect_pc[1];
      halted   <= 1'b0;
    end else begin
      if (push)
        skip_low <= 1'b0;
      if (pop && out_fault)
        halted <= 1'b1;
      else if (pop)
        pc <= pc + (compressed ? XLEN'(2) : XLEN'(4));
    end
  end

endmodule

// File: tb/tb_rv_fetch_aligner.sv
// Directed and model-checked bench for rv_fetch_aligner.
// RESET_PC=0x100, XLEN=64.
module tb_rv_fetch_aligner;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_fault;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_fault;

  int checks   = 0;
  int failures = 0;

  logic [15:0] hw [0:2007];
  int          nhw;
  int          wi;
  int          hp;
  int          cm;
  int          ninstr;
  int          pushed;
  int          popped;
  logic [31:0] d;
  logic        hc;
  logic        ev;

  always #5 clock = ~clock;

  rv_fetch_aligner #(
    .rv64     (1'b1),
    .RESET_PC (64'h100)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_fault    (in_fault),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_fault   (out_fault)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drop();
    in_valid  = 1'b0;
    in_fault  = 1'b0;
    out_ready = 1'b0;
    redirect  = 1'b0;
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_fault    = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pc", out_pc, 64'h100);

    // 32-bit addi
    in_valid = 1'b1; in_data = 32'h0000_0013;
    step(); drop();
    chk("addi_valid", out_valid, 1);
    chk("addi_instr", out_instr, 32'h0000_0013);
    chk("addi_pc", out_pc, 64'h100);
    out_ready = 1'b1;
    step(); drop();
    chk("addi_pop_valid", out_valid, 0);
    chk("addi_pop_pc", out_pc, 64'h104);

    // two c.li in one word
    in_valid = 1'b1; in_data = 32'h4501_4505;
    step(); drop();
    chk("cli0_instr", out_instr, 32'h4501_4505);
    chk("cli0_pc", out_pc, 64'h104);
    out_ready = 1'b1;
    step(); drop();
    chk("cli1_valid", out_valid, 1);
    chk("cli1_instr", out_instr, 32'h0000_4501);
    chk("cli1_pc", out_pc, 64'h106);
    out_ready = 1'b1;
    step(); drop();
    chk("cli_empty_valid", out_valid, 0);

    // straddling 32-bit instruction
    in_valid = 1'b1; in_data = 32'h0093_4505;
    step(); drop();
    chk("str_c_instr", out_instr, 32'h0093_4505);
    chk("str_c_pc", out_pc, 64'h108);
    out_ready = 1'b1;
    step(); drop();
    chk("str_half_valid", out_valid, 0);
    in_valid = 1'b1; in_data = 32'hABCD_0001;
    step(); drop();
    chk("str_valid", out_valid, 1);
    chk("str_instr", out_instr, 32'h0001_0093);
    chk("str_pc", out_pc, 64'h10A);
    out_ready = 1'b1;
    step(); drop();
    chk("str_tail_instr", out_instr, 32'h0000_ABCD);
    chk("str_tail_pc", out_pc, 64'h10E);
    out_ready = 1'b1;
    step(); drop();
    chk("str_drain_valid", out_valid, 0);

    // redirect with three halfwords buffered
    in_valid = 1'b1; in_data = 32'h0001_0001;
    step(); drop();
    in_valid = 1'b1; in_data = 32'h0002_0002; out_ready = 1'b1;
    step(); drop();
    chk("cnt3_in_ready", in_ready, 0);
    redirect = 1'b1; redirect_pc = 64'h202;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b1;
    #1;
    chk("redir_in_ready", in_ready, 0);
    step(); drop();
    chk("redir_valid", out_valid, 0);
    chk("redir_pc", out_pc, 64'h202);
    chk("redir_ready_after", in_ready, 1);
    in_valid = 1'b1; in_data = 32'h0001_FFFF;
    step(); drop();
    chk("skip_valid", out_valid, 1);
    chk("skip_instr", out_instr, 32'h0000_0001);
    chk("skip_pc", out_pc, 64'h202);
    out_ready = 1'b1;
    step(); drop();
    chk("skip_pop_valid", out_valid, 0);
    chk("skip_pop_pc", out_pc, 64'h204);

    // faulting fetch word halts until redirect
    in_valid = 1'b1; in_data = 32'h0000_0013; in_fault = 1'b1;
    step(); drop();
    chk("flt_valid", out_valid, 1);
    chk("flt_fault", out_fault, 1);
    chk("flt_pc", out_pc, 64'h204);
    out_ready = 1'b1;
    step(); drop();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h0001_0001; out_ready = 1'b1;
      #1;
      chk("halt_in_ready", in_ready, 0);
      chk("halt_valid", out_valid, 0);
      step(); drop();
    end
    redirect = 1'b1; redirect_pc = 64'h300;
    step(); drop();
    chk("unhalt_in_ready", in_ready, 1);
    chk("unhalt_valid", out_valid, 0);
    chk("unhalt_pc", out_pc, 64'h300);

    // fault only on the upper half of a straddling instruction
    in_valid = 1'b1; in_data = 32'h0093_0001;
    step(); drop();
    chk("f2_c_fault", out_fault, 0);
    in_valid = 1'b1; in_data = 32'h1234_0000; in_fault = 1'b1;
    step(); drop();
    chk("f2_c_instr", out_instr, 32'h0093_0001);
    chk("f2_c_fault2", out_fault, 0);
    out_ready = 1'b1;
    step(); drop();
    chk("f2_valid", out_valid, 1);
    chk("f2_instr", out_instr, 32'h0000_0093);
    chk("f2_pc", out_pc, 64'h302);
    chk("f2_fault", out_fault, 1);
    out_ready = 1'b1;
    step(); drop();
    chk("f2_halt_valid", out_valid, 0);

    // random mixed stream against a halfword model
    nhw = 0;
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (d[1:0] == 2'b11) d[1:0] = 2'b01;
        hw[nhw] = d[15:0];
        nhw += 1;
      end else begin
        hw[nhw]     = {d[15:2], 2'b11};
        hw[nhw + 1] = d[31:16];
        nhw += 2;
      end
    end
    for (int i = nhw; i < 2008; i++) hw[i] = 16'h0001;
    redirect = 1'b1; redirect_pc = 64'h1000;
    step(); drop();
    wi = 0; hp = 0; cm = 0; ninstr = 0;
    for (int cyc = 0; cyc < 20000 && ninstr < 1000; cyc++) begin
      in_valid  = (2 * wi < nhw) && ($urandom_range(0, 3) != 0);
      in_data   = {hw[2 * wi + 1], hw[2 * wi]};
      out_ready = (cyc >= 40) && ($urandom_range(0, 1) == 1);
      @(negedge clock);
      pushed = 0;
      popped = 0;
      hc = hw[hp][1:0] != 2'b11;
      ev = cm >= 1 && (hc || cm >= 2);
      chk("rnd_in_ready", in_ready, cm <= 2);
      chk("rnd_out_valid", out_valid, ev);
      if (ev && out_ready) begin
        if (hc) begin
          chk("rnd_instr16", out_instr[15:0], hw[hp]);
          popped = 1;
        end else begin
          chk("rnd_instr32", out_instr, {hw[hp + 1], hw[hp]});
          popped = 2;
        end
        chk("rnd_pc", out_pc, 64'h1000 + 64'(2 * hp));
        chk("rnd_fault", out_fault, 0);
        hp += popped;
        ninstr++;
      end
      if (in_valid && cm <= 2) begin
        wi++;
        pushed = 2;
      end
      cm = cm + pushed - popped;
      @(posedge clock);
      #1;
    end
    chk("rnd_completed", ninstr, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
